// File: rtl/datapath_o.sv
// Register-file datapath: decodes the 16-bit control word from the sort FSM,
// runs one ALU operation per cycle and returns registered compare flags.
module datapath_o #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      i_signal,
  input  logic             load_en,
  input  logic [3:0]       load_addr,
  input  logic [WIDTH-1:0] load_data,
  input  logic [3:0]       rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] alu_out,
  output logic             mayor,
  output logic             zero,
  output logic             neg
);

  localparam int unsigned OP_W   = 3;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned NREGS  = 16;

  typedef enum logic [OP_W-1:0] {
    OP_IDLE = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_RSUB = 3'b011,
    OP_PASA = 3'b100,
    OP_PASB = 3'b101,
    OP_AND  = 3'b110,
    OP_OR   = 3'b111
  } op_t;

  typedef struct packed {
    op_t              cnt_alu;
    logic [SEL_W-1:0] slc_mux_a;
    logic [SEL_W-1:0] slc_mux_b;
    logic [SEL_W-1:0] slc_reg;
    logic             w;
  } ctrl_t;

  ctrl_t            ctrl;
  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res;

  assign ctrl = ctrl_t'(i_signal);
  assign op_a = regs[ctrl.slc_mux_a];
  assign op_b = regs[ctrl.slc_mux_b];

  // ALU: result selected by the opcode field, wraps modulo 2^WIDTH
  always_comb begin
    res = '0;
    unique case (ctrl.cnt_alu)
      OP_IDLE: res = '0;
      OP_ADD:  res = op_a + op_b;
      OP_SUB:  res = op_a - op_b;
      OP_RSUB: res = op_b - op_a;
      OP_PASA: res = op_a;
      OP_PASB: res = op_b;
      OP_AND:  res = op_a & op_b;
      OP_OR:   res = op_a | op_b;
      default: res = '0;
    endcase
  end

  // Register file: datapath write-back has priority over the host load port
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (ctrl.w) begin
      regs[ctrl.slc_reg] <= res;
    end else if (load_en) begin
      regs[load_addr] <= load_data;
    end
  end

  // Registered ALU result and host read port (no bypass from a same-cycle write)
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_out <= '0;
      rd_data <= '0;
    end else begin
      alu_out <= res;
      rd_data <= regs[rd_addr];
    end
  end

  // Signed compare flags, updated only on a compare word and held otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      mayor <= 1'b0;
      zero  <= 1'b0;
      neg   <= 1'b0;
    end else if (ctrl.cnt_alu == OP_SUB) begin
      mayor <= $signed(op_a) >  $signed(op_b);
      zero  <= op_a == op_b;
      neg   <= $signed(op_a) <  $signed(op_b);
    end
  end

endmodule

// File: tb/tb_datapath_o.sv
// Directed self-checking bench for datapath_o.
module tb_datapath_o;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_signal;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [7:0]  load_data;
  logic [3:0]  rd_addr;
  logic [7:0]  rd_data;
  logic [7:0]  alu_out;
  logic        mayor;
  logic        zero;
  logic        neg;

  int checks = 0;
  int errors = 0;
  logic [7:0] rv;

  datapath_o #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_signal  (i_signal),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .alu_out   (alu_out),
    .mayor     (mayor),
    .zero      (zero),
    .neg       (neg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance one rising edge, land 1 time unit after it
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mkw(input logic [2:0] op, input logic [3:0] a,
                                      input logic [3:0] b, input logic [3:0] r,
                                      input logic w);
    return {op, a, b, r, w};
  endfunction

  task automatic load(input logic [3:0] addr, input logic [7:0] data);
    i_signal  = 16'h0;
    load_en   = 1'b1;
    load_addr = addr;
    load_data = data;
    cyc();
    load_en = 1'b0;
  endtask

  task automatic rd(input logic [3:0] addr, output logic [7:0] val);
    i_signal = 16'h0;
    rd_addr  = addr;
    cyc();
    val = rd_data;
  endtask

  task automatic exec(input logic [15:0] word);
    i_signal = word;
    cyc();
    i_signal = 16'h0;
  endtask

  function automatic logic [15:0] flags();
    return 16'({mayor, zero, neg});
  endfunction

  initial begin
    rst = 1'b1; i_signal = 16'h0; load_en = 1'b0; load_addr = 4'h0;
    load_data = 8'h0; rd_addr = 4'h0;
    cyc(); cyc();
    rst = 1'b0;
    check("rst_rd_data", 16'(rd_data), 16'h0);
    check("rst_alu_out", 16'(alu_out), 16'h0);
    check("rst_flags", flags(), 16'h0);

    // reset clears preloaded register
    load(4'd3, 8'h55);
    rd(4'd3, rv); check("preload_r3", 16'(rv), 16'h55);
    rst = 1'b1; cyc(); rst = 1'b0;
    rd(4'd3, rv); check("reset_r3", 16'(rv), 16'h0);
    check("reset_flags", flags(), 16'h0);

    // compares: flags = {mayor,zero,neg}
    load(4'd1, 8'h05); load(4'd2, 8'h09);
    exec(mkw(3'b010, 4'd1, 4'd2, 4'd0, 1'b0));
    check("cmp_lt_flags", flags(), 16'h1);
    check("cmp_lt_alu", 16'(alu_out), 16'hFC);
    load(4'd1, 8'h09); load(4'd2, 8'h05);
    exec(mkw(3'b010, 4'd1, 4'd2, 4'd0, 1'b0));
    check("cmp_gt_flags", flags(), 16'h4);
    check("cmp_gt_alu", 16'(alu_out), 16'h04);
    load(4'd8, 8'h09);
    exec(mkw(3'b010, 4'd1, 4'd8, 4'd0, 1'b0));
    check("cmp_eq_flags", flags(), 16'h2);
    load(4'd1, 8'hFF); load(4'd2, 8'h01);
    exec(mkw(3'b010, 4'd1, 4'd2, 4'd0, 1'b0));
    check("cmp_signed_flags", flags(), 16'h1);

    // flags hold across non-compare words
    exec(mkw(3'b100, 4'd1, 4'd0, 4'd0, 1'b0));
    check("hold_pass_flags", flags(), 16'h1);
    check("hold_pass_alu", 16'(alu_out), 16'hFF);
    exec(16'h0);
    check("hold_idle_flags", flags(), 16'h1);
    check("idle_alu", 16'(alu_out), 16'h00);
    exec(mkw(3'b100, 4'd2, 4'd0, 4'd0, 1'b0));
    check("hold_pass2_flags", flags(), 16'h1);

    // swap via temp
    load(4'd1, 8'h0A); load(4'd2, 8'h03);
    exec(mkw(3'b100, 4'd1, 4'd0, 4'd6, 1'b1));
    exec(mkw(3'b101, 4'd0, 4'd2, 4'd1, 1'b1));
    exec(mkw(3'b100, 4'd6, 4'd0, 4'd2, 1'b1));
    rd(4'd1, rv); check("swap_r1", 16'(rv), 16'h03);
    rd(4'd2, rv); check("swap_r2", 16'(rv), 16'h0A);
    rd(4'd6, rv); check("swap_r6", 16'(rv), 16'h0A);

    // write/load collision: host load dropped
    load(4'd9, 8'h11); load(4'd4, 8'h22);
    i_signal = mkw(3'b100, 4'd9, 4'd0, 4'd5, 1'b1);
    load_en = 1'b1; load_addr = 4'd4; load_data = 8'h77;
    cyc();
    load_en = 1'b0; i_signal = 16'h0;
    rd(4'd5, rv); check("coll_r5", 16'(rv), 16'h11);
    rd(4'd4, rv); check("coll_r4", 16'(rv), 16'h22);

    // remaining opcodes with r10=0x3C, r11=0x0F
    load(4'd10, 8'h3C); load(4'd11, 8'h0F);
    exec(mkw(3'b011, 4'd10, 4'd11, 4'd0, 1'b0)); check("op_bsuba", 16'(alu_out), 16'hD3);
    exec(mkw(3'b110, 4'd10, 4'd11, 4'd0, 1'b0)); check("op_and", 16'(alu_out), 16'h0C);
    exec(mkw(3'b111, 4'd10, 4'd11, 4'd0, 1'b0)); check("op_or", 16'(alu_out), 16'h3F);
    exec(mkw(3'b101, 4'd10, 4'd11, 4'd0, 1'b0)); check("op_passb", 16'(alu_out), 16'h0F);
    check("ops_flags_held", flags(), 16'h1);

    // wrap and self-reference
    load(4'd7, 8'hFF);
    exec(mkw(3'b001, 4'd7, 4'd7, 4'd7, 1'b1));
    check("wrap_alu", 16'(alu_out), 16'hFE);
    rd(4'd7, rv); check("wrap_r7", 16'(rv), 16'hFE);

    // same-cycle read of a register being written returns old value
    rd_addr = 4'd7;
    i_signal = mkw(3'b001, 4'd7, 4'd7, 4'd7, 1'b1);
    cyc();
    i_signal = 16'h0;
    check("nobypass_rd", 16'(rd_data), 16'hFE);
    check("nobypass_alu", 16'(alu_out), 16'hFC);
    rd(4'd7, rv); check("after_write_r7", 16'(rv), 16'hFC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
